// File: rtl/board_drop_controller.sv
// Connect Four board store and drop sequencer: scans a column, places a piece,
// then hands the move to the victory checker and latches its verdict.
// Ports: drop_valid/drop_col/drop_player -> drop_ready/drop_done/drop_ok,
//   move_row/move_col/check_start -> checker, check_done/winner_in <- checker,
//   check_row_read/check_col_read -> check_data, clear_board,
//   game_winner, board_full.
module board_drop_controller #(
  parameter int ROWS = 6,
  parameter int COLS = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       drop_valid,
  input  logic [2:0] drop_col,
  input  logic [1:0] drop_player,
  output logic       drop_ready,
  output logic       drop_done,
  output logic       drop_ok,
  output logic [2:0] move_row,
  output logic [2:0] move_col,
  output logic       check_start,
  input  logic       check_done,
  input  logic [1:0] winner_in,
  input  logic [2:0] check_row_read,
  input  logic [2:0] check_col_read,
  output logic [1:0] check_data,
  input  logic       clear_board,
  output logic [1:0] game_winner,
  output logic       board_full
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SCAN  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // 7-bit count so an 8x8 board can still reach its 64-cell full mark
  localparam logic [6:0] NCELL = 7'(ROWS * COLS);
  localparam logic [2:0] TOPROW = 3'(ROWS - 1);

  function automatic logic [5:0] cidx(
    input logic [2:0] r,
    input logic [2:0] c
  );
    return 6'(r) * 6'(COLS) + 6'(c);
  endfunction

  // Sized to the largest board; unused entries stay zero
  logic [1:0] cells_q [64];

  logic [2:0] state_q, state_d;
  logic [2:0] scan_q, scan_d;
  logic       ok_q, ok_d;
  logic [2:0] col_q;
  logic [1:0] ply_q;
  logic [2:0] mrow_q, mcol_q;
  logic [6:0] cnt_q;
  logic [1:0] win_q;
  logic       clrp_q;

  logic idle, do_clear, accept, bad_req;
  logic scan_empty, scan_top;
  logic [1:0] scan_cell;

  assign idle       = (state_q == S_IDLE);
  assign board_full = (cnt_q == NCELL);
  assign drop_ready = idle & (win_q == 2'b00) & ~board_full;
  // A pending or fresh clear takes the IDLE cycle and blocks acceptance
  assign do_clear   = idle & (clear_board | clrp_q);
  assign accept     = drop_valid & drop_ready & ~do_clear;
  assign bad_req    = ({1'b0, drop_col} >= 4'(COLS)) |
                      (drop_player == 2'b00) |
                      (drop_player == 2'b11);

  assign scan_cell  = cells_q[cidx(scan_q, col_q)];
  assign scan_empty = (scan_cell == 2'b00);
  assign scan_top   = (scan_q == TOPROW);

  assign drop_done   = (state_q == S_DONE);
  assign drop_ok     = (state_q == S_DONE) & ok_q;
  assign check_start = (state_q == S_CHECK);
  assign move_row    = mrow_q;
  assign move_col    = mcol_q;
  assign game_winner = win_q;

  always_comb begin
    check_data = 2'b00;
    if (({1'b0, check_row_read} < 4'(ROWS)) &&
        ({1'b0, check_col_read} < 4'(COLS)))
      check_data = cells_q[cidx(check_row_read, check_col_read)];
  end

  always_comb begin
    state_d = state_q;
    scan_d  = scan_q;
    ok_d    = ok_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bad_req) begin
            state_d = S_DONE;
            ok_d    = 1'b0;
          end else begin
            state_d = S_SCAN;
            scan_d  = 3'd0;
          end
        end
      end
      S_SCAN: begin
        if (scan_empty) begin
          state_d = S_WRITE;
        end else if (scan_top) begin
          state_d = S_DONE;
          ok_d    = 1'b0;
        end else begin
          scan_d = scan_q + 3'd1;
        end
      end
      S_WRITE: state_d = S_CHECK;
      S_CHECK: state_d = S_WAIT;
      S_WAIT: begin
        if (check_done) begin
          state_d = S_DONE;
          ok_d    = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      scan_q  <= 3'd0;
      ok_q    <= 1'b0;
      col_q   <= 3'd0;
      ply_q   <= 2'b00;
      mrow_q  <= 3'd0;
      mcol_q  <= 3'd0;
      cnt_q   <= 7'd0;
      win_q   <= 2'b00;
      clrp_q  <= 1'b0;
      for (int i = 0; i < 64; i++) cells_q[i] <= 2'b00;
    end else begin
      state_q <= state_d;
      scan_q  <= scan_d;
      ok_q    <= ok_d;
      if (accept) begin
        col_q <= drop_col;
        ply_q <= drop_player;
      end
      if (do_clear)
        clrp_q <= 1'b0;
      else if (clear_board && !idle)
        clrp_q <= 1'b1;
      if (state_q == S_WRITE) begin
        cells_q[cidx(scan_q, col_q)] <= ply_q;
        mrow_q <= scan_q;
        mcol_q <= col_q;
        if (cnt_q != NCELL) cnt_q <= cnt_q + 7'd1;
      end
      if (state_q == S_WAIT && check_done && winner_in != 2'b00)
        win_q <= winner_in;
      if (do_clear) begin
        for (int i = 0; i < 64; i++) cells_q[i] <= 2'b00;
        cnt_q <= 7'd0;
        win_q <= 2'b00;
      end
    end
  end

endmodule
